iro_serial_tx: RTL and testbench



---
 rtl/iro_serial_tx_pkg.sv | 19 +
 rtl/iro_serial_tx_if.sv | 23 ++
 rtl/iro_serial_tx_timer.sv | 27 ++
 rtl/iro_serial_tx.sv | 126 ++++++++++++
 tb/tb_iro_serial_tx.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/iro_serial_tx_pkg.sv
// Shared types and defaults for the ring-oscillator serial transmitter.
// Parity bit is enabled by defining IRO_SERIAL_TX_PARITY_EN.
package iro_pkg;

  localparam int IRO_CFG_WIDTH = 16;
  localparam int IRO_DIV_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } iro_tx_state_t;

  function automatic int iro_bcnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/iro_serial_tx_if.sv
// Valid/ready word handshake into the serial transmitter.
// Master is the control-side source, slave is the transmitter.
interface iro_serial_tx_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/iro_serial_tx_timer.sv
// Loadable half-period down-counter; tick is high once cnt reaches 0,
// i.e. div+1 cycles after a load.
module iro_half_period_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/iro_serial_tx.sv
// MSB-first bdat/bclk serial transmitter for the ring oscillator.
// Optional even-parity bit: define IRO_SERIAL_TX_PARITY_EN.
module iro_serial_tx
  import iro_pkg::*;
#(
  parameter int WIDTH = IRO_CFG_WIDTH,
  parameter int DIV_W = IRO_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  iro_serial_tx_if.slave   tx,
  input  logic [DIV_W-1:0] div,
  output logic             bclk,
  output logic             bdat,
  output logic             busy,
  output logic             done
);

  localparam int BCW = iro_bcnt_w(WIDTH);
`ifdef IRO_SERIAL_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [BCW-1:0] NLOAD = BCW'(NBITS);

  iro_tx_state_t    state;
  // The MSB goes straight to bdat, so only the rest is stored.
  logic [WIDTH-2:0] sr;
  logic [DIV_W-1:0] div_r;
  logic [BCW-1:0]   bcnt;
  logic             shift_in;
  logic             accept;
  logic             last;
  logic             tick;
  logic             t_load;
  logic [DIV_W-1:0] t_val;

  assign tx.tx_ready = (state == IDLE);
  assign accept      = tx.tx_valid & tx.tx_ready;
  assign last        = (bcnt == BCW'(1));

  assign t_load = accept
                | ((state == LOW) & tick)
                | ((state == HIGH) & tick & ~last);
  assign t_val  = accept ? div : div_r;

`ifdef IRO_SERIAL_TX_PARITY_EN
  logic par_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r <= 1'b0;
    end else if (accept) begin
      par_r <= ^tx.tx_data;
    end
  end

  assign shift_in = par_r;
`else
  assign shift_in = 1'b0;
`endif

  iro_half_period_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      div_r <= '0;
      bcnt  <= '0;
      bclk  <= 1'b0;
      bdat  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx.tx_valid) begin
            sr    <= tx.tx_data[WIDTH-2:0];
            bdat  <= tx.tx_data[WIDTH-1];
            div_r <= div;
            bcnt  <= NLOAD;
            busy  <= 1'b1;
            state <= LOW;
          end
        end
        LOW: begin
          if (tick) begin
            bclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            bclk <= 1'b0;
            if (last) begin
              bdat  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bdat  <= sr[WIDTH-2];
              sr    <= {sr[WIDTH-3:0], shift_in};
              bcnt  <= bcnt - BCW'(1);
              state <= LOW;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iro_serial_tx.sv
// Scoreboard bench for iro_serial_tx: expected bits/timing queued at
// accept, checked by a negedge monitor on bclk rises and done pulses.
module tb_iro_serial_tx;

  localparam int W  = 16;
  localparam int DW = 8;
`ifdef IRO_SERIAL_TX_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif
  localparam int TMO = 5000;

  typedef struct {
    logic b;
    int   c;
  } exp_bit_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] div;
  logic          bclk;
  logic          bdat;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_bit_t bq[$];
  int       dq[$];
  exp_bit_t me;
  int       md;
  logic     prev_bclk = 1'b0;

  iro_serial_tx_if #(.WIDTH(W)) tx();

  iro_serial_tx #(
    .WIDTH(W),
    .DIV_W(DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx    (tx),
    .div   (div),
    .bclk  (bclk),
    .bdat  (bdat),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cyc %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bclk && !prev_bclk) begin
        if (bq.size() == 0) begin
          fail("unexpected_bclk_rise");
        end else begin
          me = bq.pop_front();
          chk("bdat_at_rise", int'(bdat), int'(me.b));
          chk("rise_cycle", cyc, me.c);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          fail("unexpected_done");
        end else begin
          md = dq.pop_front();
          chk("done_cycle", cyc, md);
        end
      end
    end
    prev_bclk = bclk;
  end

  // Called at a negedge where tx_ready is high and tx_valid is driven.
  task automatic issue(input logic [W-1:0] d, input logic [DW-1:0] dv,
                       output int e);
    exp_bit_t x;
    int h;
    tx.tx_data = d;
    div = dv;
    e = cyc + 1;
    h = int'(dv) + 1;
    for (int i = 0; i < N; i++) begin
      x.b = (i < W) ? d[W-1-i] : ^d;
      x.c = e + h + 2 * i * h;
      bq.push_back(x);
    end
    dq.push_back(e + 2 * N * h);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [DW-1:0] dv,
                      output int e);
    int t;
    @(negedge clk);
    tx.tx_valid = 1'b1;
    t = 0;
    while (!tx.tx_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) fail("ready_timeout");
    issue(d, dv, e);
    @(posedge clk);
    #1 tx.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((bq.size() != 0 || dq.size() != 0 || !tx.tx_ready) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) fail("idle_timeout");
  endtask

  initial begin
    int e1;
    int e2;
    int t;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    div         = '0;

    repeat (3) @(negedge clk);
    chk("rst_bclk", int'(bclk), 0);
    chk("rst_bdat", int'(bdat), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(tx.tx_ready), 1);

    // Basic transfer at full rate
    send(16'hA5C3, 8'd0, e1);
    @(negedge clk);
    chk("busy_in_xfer", int'(busy), 1);
    chk("ready_in_xfer", int'(tx.tx_ready), 0);
    wait_idle();

    // Slow bit clock
    send(16'h0001, 8'd3, e1);
    wait_idle();

    // valid held with changing data/div: only the first word counts
    send(16'h1234, 8'd0, e1);
    tx.tx_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!tx.tx_ready && t < TMO) begin
      tx.tx_data = W'($urandom);
      div = DW'($urandom);
      @(negedge clk);
      t++;
    end
    if (t >= TMO) fail("b2b_timeout");
    issue(16'h5A5A, 8'd0, e2);
    chk("b2b_accept_edge", e2, e1 + 2 * N + 2);
    @(posedge clk);
    #1 tx.tx_valid = 1'b0;
    wait_idle();

    // Reset in the middle of bit 7
    send(16'hC3A5, 8'd1, e1);
    t = 0;
    while (bq.size() > N - 7 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) fail("bit7_timeout");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bclk", int'(bclk), 0);
    chk("mid_rst_bdat", int'(bdat), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ready", int'(tx.tx_ready), 1);
    bq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(16'hFFFF, 8'd0, e1);
    wait_idle();

    // Parity-relevant word (parity bit 1 when enabled)
    send(16'h0007, 8'd0, e1);
    wait_idle();

    // Large divider, short word pattern
    send(16'h8000, 8'd9, e1);
    wait_idle();

    repeat (4) @(negedge clk);
    chk("final_bq_empty", bq.size(), 0);
    chk("final_dq_empty", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
